lsu_strided: RTL



---
 rtl/lsu_strided.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lsu_strided.sv
// Strided vector load/store sequencer: walks base + k*stride for up to els_p
// elements, issuing one local DMEM access or one remote request per element.
module lsu_strided #(
  parameter int  data_width_p       = 32,
  parameter int  dmem_size_p        = 1024,
  parameter int  els_p              = 4,
  localparam int dmem_addr_width_lp = $clog2(dmem_size_p),
  localparam int cnt_width_lp       = $clog2(els_p + 1),
  localparam int el_width_lp        = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          v_i,
  output logic                          ready_o,
  input  logic                          is_store_i,
  input  logic [data_width_p-1:0]       base_addr_i,
  input  logic [data_width_p-1:0]       stride_i,
  input  logic [cnt_width_lp-1:0]       count_i,
  input  logic [els_p*data_width_p-1:0] data_i,
  input  logic [4:0]                    rd_i,
  output logic                          dmem_v_o,
  output logic                          dmem_w_o,
  output logic [dmem_addr_width_lp-1:0] dmem_addr_o,
  output logic [data_width_p-1:0]       dmem_data_o,
  output logic [3:0]                    dmem_mask_o,
  output logic                          remote_v_o,
  input  logic                          remote_ready_i,
  output logic                          remote_w_o,
  output logic [data_width_p-1:0]       remote_addr_o,
  output logic [data_width_p-1:0]       remote_data_o,
  output logic [4:0]                    remote_reg_id_o,
  output logic [el_width_lp-1:0]        remote_el_o,
  output logic                          done_o,
  output logic                          err_o
);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                    state_q, state_d;
  logic [data_width_p-1:0]   addr_q, addr_d;
  logic [data_width_p-1:0]   stride_q;
  logic [cnt_width_lp-1:0]   idx_q, idx_d;
  logic [cnt_width_lp-1:0]   count_q;
  logic                      is_store_q;
  logic [4:0]                rd_q;
  logic [data_width_p-1:0]   data_q [els_p];
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      capture;
  logic                      misaligned, local_hit, last_el;
  logic [data_width_p-1:0]   cur_data;

  assign misaligned = (addr_q[1:0] != 2'b00);
  // Bits 31:12 all zero means the address falls in the 4 KB local DMEM window.
  assign local_hit  = (addr_q[31:12] == '0);
  assign last_el    = (idx_q == count_q - cnt_width_lp'(1));
  assign cur_data   = data_q[idx_q[el_width_lp-1:0]];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      is_store_q <= 1'b0;
      rd_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int k = 0; k < els_p; k++) data_q[k] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (capture) begin
        is_store_q <= is_store_i;
        rd_q       <= rd_i;
        count_q    <= count_i;
        stride_q   <= stride_i;
        for (int k = 0; k < els_p; k++)
          data_q[k] <= data_i[k*data_width_p +: data_width_p];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    capture    = 1'b0;
    dmem_v_o   = 1'b0;
    remote_v_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (v_i) begin
          capture = 1'b1;
          addr_d  = base_addr_i;
          idx_d   = '0;
          if (count_i == '0) done_d  = 1'b1;
          else               state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (misaligned) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          dmem_v_o   = local_hit;
          remote_v_o = !local_hit;
          // DMEM never stalls; remote elements advance only on ready.
          if (local_hit || remote_ready_i) begin
            addr_d = addr_q + stride_q;
            idx_d  = idx_q + cnt_width_lp'(1);
            if (last_el) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_o         = reset_n_i && (state_q == IDLE);
  assign dmem_w_o        = dmem_v_o & is_store_q;
  assign dmem_addr_o     = addr_q[2 +: dmem_addr_width_lp];
  assign dmem_data_o     = cur_data;
  assign dmem_mask_o     = {4{dmem_v_o}};
  assign remote_w_o      = remote_v_o & is_store_q;
  assign remote_addr_o   = addr_q;
  assign remote_data_o   = cur_data;
  assign remote_reg_id_o = rd_q;
  assign remote_el_o     = idx_q[el_width_lp-1:0];
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule
